// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encodings, operate-class opcodes and condition-code values
// shared by the operand-fetch stage and the ALU.
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    ALUK_ADD   = 2'd0,
    ALUK_AND   = 2'd1,
    ALUK_XOR   = 2'd2,
    ALUK_PASSA = 2'd3
  } aluk_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b1001;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  function automatic logic is_operate(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
  endfunction

  function automatic aluk_e decode_aluk(input logic [3:0] op);
    case (op)
      OP_AND:  return ALUK_AND;
      OP_XOR:  return ALUK_XOR;
      default: return ALUK_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// reg_file: NREGS x WIDTH register file, two async read ports, one sync write port.
// WB_BYPASS_EN: reads of the register being written this cycle return the write data.
`default_nettype none

module reg_file
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  output logic [WIDTH-1:0]         rd_data_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_b,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
`endif

endmodule

`default_nettype wire

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: decode/operand-fetch for LC-3b operate instructions, with scoreboard,
// condition codes and a registered valid/ready output. Optional macro: WB_BYPASS_EN.
`default_nettype none

module alu_operand_fetch
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [15:0]      INST,
  input  logic             INST_VALID,
  output logic             INST_READY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       ALUK,
  output logic [2:0]       DR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             WB_EN,
  input  logic [2:0]       WB_DR,
  input  logic [WIDTH-1:0] WB_DATA,
  output logic [2:0]       CC,
  output logic             ILLEGAL
);

  logic [3:0]       opcode;
  logic [2:0]       dr_f, sr1, sr2;
  logic             imm_sel, legal, stall, accept;
  logic [WIDTH-1:0] rd_a, rd_b, b_val, sext_imm;
  logic [NREGS-1:0] pending, pend_view, wb_clear, set_mask;

  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       aluk_q;
  logic [2:0]       dr_q, cc_q;
  logic             valid_q, illegal_q;

  assign opcode   = INST[15:12];
  assign dr_f     = INST[11:9];
  assign sr1      = INST[8:6];
  assign sr2      = INST[2:0];
  assign imm_sel  = INST[5];
  assign sext_imm = {{(WIDTH-5){INST[4]}}, INST[4:0]};
  assign legal    = is_operate(opcode);

  reg_file #(.NREGS(NREGS), .WIDTH(WIDTH)) u_reg_file (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .rd_addr_a (sr1),
    .rd_data_a (rd_a),
    .rd_addr_b (sr2),
    .rd_data_b (rd_b),
    .wr_en     (WB_EN),
    .wr_addr   (WB_DR),
    .wr_data   (WB_DATA)
  );

  assign wb_clear = WB_EN ? (NREGS'(1) << WB_DR) : '0;
  assign set_mask = NREGS'(1) << dr_f;

  // With bypass, a write-back landing this cycle already satisfies the dependency.
`ifdef WB_BYPASS_EN
  assign pend_view = pending & ~wb_clear;
`else
  assign pend_view = pending;
`endif

  assign stall = legal && (pend_view[sr1] || (!imm_sel && pend_view[sr2]) || pend_view[dr_f]);
  assign INST_READY = (!valid_q || OUT_READY) && !stall;
  assign accept     = INST_VALID && INST_READY;
  assign b_val      = imm_sel ? sext_imm : rd_b;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      aluk_q    <= ALUK_ADD;
      dr_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
      if (accept && legal) begin
        valid_q <= 1'b1;
        a_q     <= rd_a;
        b_q     <= b_val;
        aluk_q  <= decode_aluk(opcode);
        dr_q    <= dr_f;
      end else if (valid_q && OUT_READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Clear first, then set, so an issue to the register being written back keeps it pending.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wb_clear) | ((accept && legal) ? set_mask : '0);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cc_q <= CC_Z;
    end else if (WB_EN) begin
      if (WB_DATA[WIDTH-1])  cc_q <= CC_N;
      else if (WB_DATA == '0) cc_q <= CC_Z;
      else                   cc_q <= CC_P;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALUK      = aluk_q;
  assign DR        = dr_q;
  assign OUT_VALID = valid_q;
  assign CC        = cc_q;
  assign ILLEGAL   = illegal_q;

endmodule

`default_nettype wire
